// File: rtl/regfile_write_scheduler.sv
// Round-robin writeback arbiter for the integer register file write port,
// with a registered write stage and a pending-write scoreboard for issue.
module regfile_write_scheduler #(
  parameter int unsigned num_requesters = 3,
  parameter int unsigned num_registers  = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [num_requesters-1:0]   in_req_valid,
  input  logic [5*num_requesters-1:0] in_req_register,
  input  logic [32*num_requesters-1:0] in_req_data,
  output logic [num_requesters-1:0]   out_req_ready,
  input  logic                        in_reserve_valid,
  input  logic [4:0]                  in_reserve_register,
  output logic                        out_write_enable,
  output logic [4:0]                  out_write_register_select,
  output logic [31:0]                 out_write_data,
  output logic [num_registers-1:0]    out_busy,
  output logic [((num_requesters > 1) ? $clog2(num_requesters) : 1)-1:0] out_grant_index
);

  localparam int unsigned idx_w  = (num_requesters > 1) ? $clog2(num_requesters) : 1;
  localparam int unsigned reg_w  = 5;
  localparam int unsigned data_w = 32;

  logic [idx_w-1:0]         rr_ptr;
  logic [idx_w-1:0]         grant;
  logic [idx_w-1:0]         scan;
  logic                     found;
  logic [reg_w-1:0]         grant_register;
  logic [data_w-1:0]        grant_data;
  logic [num_registers-1:0] busy_next;

  // Scan requesters starting at rr_ptr; first valid one wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    scan  = rr_ptr;
    for (int k = 0; k < int'(num_requesters); k++) begin
      if (!found && in_req_valid[scan]) begin
        found = 1'b1;
        grant = scan;
      end
      scan = (scan == idx_w'(num_requesters - 1)) ? '0 : scan + 1'b1;
    end
    if (RESET) found = 1'b0;
  end

  // One-hot ready plus payload mux for the winning requester.
  always_comb begin
    out_req_ready  = '0;
    grant_register = '0;
    grant_data     = '0;
    for (int i = 0; i < int'(num_requesters); i++) begin
      if (found && grant == idx_w'(i)) begin
        out_req_ready[i] = 1'b1;
        grant_register   = in_req_register[i*reg_w +: reg_w];
        grant_data       = in_req_data[i*data_w +: data_w];
      end
    end
  end

  // Clear on commit first, then reserve, so a same-edge reserve wins.
  always_comb begin
    busy_next = out_busy;
    if (out_write_enable) busy_next[out_write_register_select] = 1'b0;
    if (in_reserve_valid && in_reserve_register != '0) busy_next[in_reserve_register] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr                    <= '0;
      out_write_enable          <= 1'b0;
      out_write_register_select <= '0;
      out_write_data            <= '0;
      out_grant_index           <= '0;
      out_busy                  <= '0;
    end else begin
      out_write_enable <= 1'b0;
      out_busy         <= busy_next;
      if (found) begin
        rr_ptr                    <= (grant == idx_w'(num_requesters - 1)) ? '0 : grant + 1'b1;
        out_write_register_select <= grant_register;
        out_write_data            <= grant_data;
        out_grant_index           <= grant;
        // x0 writes are acknowledged but never reach the register file.
        out_write_enable          <= (grant_register != '0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized checks of regfile_write_scheduler against a
// cycle-level behavioural model of arbitration, write port and scoreboard.
module tb_regfile_write_scheduler;

  localparam int N = 3;

  logic          CLK;
  logic          RESET;
  logic [N-1:0]  in_req_valid;
  logic [5*N-1:0] in_req_register;
  logic [32*N-1:0] in_req_data;
  logic [N-1:0]  out_req_ready;
  logic          in_reserve_valid;
  logic [4:0]    in_reserve_register;
  logic          out_write_enable;
  logic [4:0]    out_write_register_select;
  logic [31:0]   out_write_data;
  logic [31:0]   out_busy;
  logic [1:0]    out_grant_index;

  regfile_write_scheduler #(.num_requesters(N), .num_registers(32)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .in_req_valid(in_req_valid),
    .in_req_register(in_req_register),
    .in_req_data(in_req_data),
    .out_req_ready(out_req_ready),
    .in_reserve_valid(in_reserve_valid),
    .in_reserve_register(in_reserve_register),
    .out_write_enable(out_write_enable),
    .out_write_register_select(out_write_register_select),
    .out_write_data(out_write_data),
    .out_busy(out_busy),
    .out_grant_index(out_grant_index)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  int          m_rr;
  bit          m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  int          m_gi;
  bit   [31:0] m_busy;
  logic [4:0]  t_reg[N];
  logic [31:0] t_data[N];
  int          last_grant;
  logic [N-1:0] obs_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input bit rst, input logic [N-1:0] v);
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check registered outputs, drive inputs, check ready, advance model.
  task automatic cycle(input bit rst, input logic [N-1:0] v, input logic [5*N-1:0] regs,
                       input logic [32*N-1:0] dat, input bit rv, input logic [4:0] rreg);
    int g;
    @(negedge CLK);
    check("write_enable", 64'(out_write_enable), 64'(m_we));
    check("write_select", 64'(out_write_register_select), 64'(m_sel));
    check("write_data", 64'(out_write_data), 64'(m_data));
    check("grant_index", 64'(out_grant_index), 64'(m_gi));
    check("busy", 64'(out_busy), 64'(m_busy));
    for (int i = 0; i < N; i++) begin
      t_reg[i]  = regs[i*5 +: 5];
      t_data[i] = dat[i*32 +: 32];
    end
    RESET               = rst;
    in_req_valid        = v;
    in_req_register     = regs;
    in_req_data         = dat;
    in_reserve_valid    = rv;
    in_reserve_register = rreg;
    #1;
    g = model_grant(rst, v);
    obs_ready  = out_req_ready;
    last_grant = g;
    check("ready", 64'(out_req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    @(posedge CLK);
    if (rst) begin
      m_rr = 0; m_we = 0; m_sel = '0; m_data = '0; m_gi = 0; m_busy = '0;
    end else begin
      if (m_we) m_busy[m_sel] = 1'b0;
      if (rv && rreg != 5'd0) m_busy[rreg] = 1'b1;
      if (g >= 0) begin
        m_rr   = (g + 1) % N;
        m_sel  = t_reg[g];
        m_data = t_data[g];
        m_gi   = g;
        m_we   = (t_reg[g] != 5'd0);
      end else begin
        m_we = 0;
      end
    end
  endtask

  localparam logic [5*N-1:0]  R0 = '0;
  localparam logic [32*N-1:0] D0 = '0;

  initial begin
    RESET = 1'b1;
    in_req_valid = '0; in_req_register = '0; in_req_data = '0;
    in_reserve_valid = 1'b0; in_reserve_register = '0;
    m_rr = 0; m_we = 0; m_sel = '0; m_data = '0; m_gi = 0; m_busy = '0;
    last_grant = -1; obs_ready = '0;
    repeat (2) @(posedge CLK);

    cycle(1, '0, R0, D0, 0, 5'd0);
    #1;
    check("reset_busy", 64'(out_busy), 64'd0);
    check("reset_we", 64'(out_write_enable), 64'd0);

    // Single request from requester 0.
    cycle(0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 0, 5'd0);
    check("tp1_ready", 64'(obs_ready), 64'b001);
    #1;
    check("tp1_we", 64'(out_write_enable), 64'd1);
    check("tp1_sel", 64'(out_write_register_select), 64'd5);
    check("tp1_data", 64'(out_write_data), 64'hDEADBEEF);
    check("tp1_gidx", 64'(out_grant_index), 64'd0);

    // Continuous requests from all, starting at rr_ptr = 0.
    cycle(1, '0, R0, D0, 0, 5'd0);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0 + 32'(k), 32'hB0 + 32'(k), 32'hA0 + 32'(k)}, 0, 5'd0);
      check("rr_order", 64'(last_grant), 64'(k % 3));
      #1;
      check("rr_back_to_back", 64'(out_write_enable), 64'd1);
    end

    // Write to x0 is accepted but dropped.
    cycle(0, 3'b001, {5'd0, 5'd0, 5'd0}, {64'd0, 32'h1234}, 0, 5'd0);
    check("x0_ready", 64'(obs_ready), 64'b001);
    #1;
    check("x0_we", 64'(out_write_enable), 64'd0);
    check("x0_busy", 64'(out_busy), 64'd0);

    // Reserve x7, write it two cycles later from requester 1.
    cycle(0, '0, R0, D0, 1, 5'd7);
    #1 check("sb_set", 64'(out_busy[7]), 64'd1);
    cycle(0, '0, R0, D0, 0, 5'd0);
    cycle(0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h7777, 32'd0}, 0, 5'd0);
    #1;
    check("sb_hold_wp", 64'(out_busy[7]), 64'd1);
    check("sb_wp_we", 64'(out_write_enable), 64'd1);
    cycle(0, '0, R0, D0, 0, 5'd0);
    #1 check("sb_clear", 64'(out_busy[7]), 64'd0);

    // Same-edge reserve and clear of x9.
    cycle(0, '0, R0, D0, 1, 5'd9);
    cycle(0, 3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h9999}, 0, 5'd0);
    cycle(0, '0, R0, D0, 1, 5'd9);
    #1 check("sb_same_edge", 64'(out_busy[9]), 64'd1);

    // Reset on top of an accepted write.
    cycle(0, '0, R0, D0, 1, 5'd3);
    cycle(0, 3'b111, {5'd4, 5'd5, 5'd6}, {32'h3, 32'h2, 32'h1}, 0, 5'd0);
    cycle(1, 3'b111, {5'd4, 5'd5, 5'd6}, {32'h3, 32'h2, 32'h1}, 1, 5'd8);
    #1;
    check("rst_we", 64'(out_write_enable), 64'd0);
    check("rst_busy", 64'(out_busy), 64'd0);
    cycle(0, 3'b111, {5'd4, 5'd5, 5'd6}, {32'h3, 32'h2, 32'h1}, 0, 5'd0);
    check("rst_first_grant", 64'(obs_ready), 64'b001);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 39) == 0), N'($urandom), 15'($urandom),
            {$urandom, $urandom, $urandom}, ($urandom_range(0, 2) == 0), 5'($urandom));
    end
    cycle(1, '0, R0, D0, 0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the 32-entry, 32-bit integer register file between several writeback requesters (ALU, load unit, CSR unit) using round-robin arbitration. It drives the register file write port through one registered stage. It also keeps a pending-write scoreboard that the issue stage reserves against and reads. It sits between the execution units and the register file, in the same clock domain as the core.

## Interface
- num_requesters, 3, number of writeback requesters (≥2); requester index width = max(1, clog2(num_requesters))
- num_registers, 32, number of architectural registers; register index width 5
- CLK  input  1  core clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- in_req_valid  input  num_requesters  per-requester write request valid
- in_req_register  input  5*num_requesters  destination register; requester i uses bits [5i+4:5i]
- in_req_data  input  32*num_requesters  write data; requester i uses bits [32i+31:32i]
- out_req_ready  output  num_requesters  one-hot grant; a request is accepted when valid and ready are both high
- in_reserve_valid  input  1  issue stage marks a destination register as pending
- in_reserve_register  input  5  register being reserved
- out_write_enable  output  1  register file write enable
- out_write_register_select  output  5  register file write address
- out_write_data  output  32  register file write data
- out_busy  output  num_registers  scoreboard; bit r = 1 means a write to register r is outstanding
- out_grant_index  output  index width  index of the requester accepted in the previous cycle (valid while out_write_enable is high)

## Operation
- Arbitration is combinational and round-robin over in_req_valid:
  - rr_ptr holds the highest-priority index.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo num_requesters.
  - The first valid requester gets out_req_ready; all other ready bits are 0.
- No valid request: out_req_ready = 0 and rr_ptr is held.
- On acceptance of requester g: rr_ptr ← (g+1) mod num_requesters. When g = num_requesters-1, rr_ptr wraps to 0.
- Output stage: on acceptance, the stage loads out_write_register_select ← register, out_write_data ← data, out_grant_index ← g. Then:
  - out_write_enable ← 1 if register ≠ 0.
  - out_write_enable ← 0 if register = 0. The x0 write is acknowledged but dropped.
- Output stage with no acceptance: out_write_enable ← 0. Select, data and index hold their previous values.
- The register file never back-pressures, so at most one write is accepted per cycle and none stall.
- Scoreboard: busy[r] is set at the edge where in_reserve_valid is high and in_reserve_register = r, for r ≠ 0.
  - Reserving register 0 is ignored; busy[0] is always 0.
- busy[r] is cleared at the edge where out_write_enable = 1 and out_write_register_select = r. This is the same edge on which the register file commits the data, so a reader that sees busy = 0 always reads the new value.
- Reserve and clear of the same register at the same edge: busy stays 1. The newer producer owns the register.
- Reserving an already-busy register keeps it at 1. No counting is done: the issue stage guarantees a single outstanding producer per register.

## Timing
- Reset (RESET high at an edge) sets rr_ptr = 0, out_write_enable = 0, out_write_register_select = 0, out_write_data = 0, out_grant_index = 0 and out_busy = 0.
- While RESET is high, out_req_ready = 0 and reserves are ignored.
- Reset asserted mid-operation discards any registered write: out_write_enable is 0 in the cycle after the reset edge and no scoreboard clear occurs.
- Latency: a request accepted in cycle n appears on the write port in cycle n+1 and is committed to the register file at the end of n+1. Its busy bit drops in cycle n+2.
- out_req_ready depends combinationally on in_req_valid and rr_ptr only. It must not depend on ready or on other outputs, so no combinational loop can form.
- Throughput is one write per cycle. Under continuous requests from all requesters, each requester is granted once every num_requesters cycles.

## Test plan
- Reset, then in_req_valid=3'b001, reg=5, data=0xDEADBEEF:
  - ready=3'b001 in cycle n.
  - Cycle n+1: out_write_enable=1, select=5, data=0xDEADBEEF, out_grant_index=0.
- All three valid for 6 cycles from rr_ptr=0:
  - Grants are 0,1,2,0,1,2, wrapping after index 2.
  - Registers written back-to-back with no idle cycle.
- Request to register 0 with data 0x1234:
  - ready=1 and the request is accepted.
  - Next cycle out_write_enable=0; busy unchanged.
- Reserve reg 7; two cycles later requester 1 writes reg 7:
  - busy[7]=1 from the cycle after the reserve.
  - It stays 1 through the acceptance cycle and the write-port cycle.
  - busy[7]=0 the cycle after out_write_enable=1.
- Same-edge reserve of reg 9 while out_write_enable=1 with select=9: busy[9] remains 1.
- RESET asserted in the cycle a request is accepted:
  - Next cycle out_write_enable=0, busy=0 and rr_ptr=0.
  - With all valid after reset, the first grant goes to requester 0.
